// File: rtl/reg_file_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Provides the reset-content modes and the per-index initial value.
package regfile_pkg;

   localparam int unsigned INIT_ZERO  = 32'd0;
   localparam int unsigned INIT_INDEX = 32'd1;

   // Register index truncated to the data width, used as the reset value in index mode.
   function automatic logic [31:0] init_value(input int unsigned idx, input int unsigned width);
      logic [31:0] mask;
      if (width >= 32'd32) begin
         mask = 32'hFFFF_FFFF;
      end else begin
         mask = (32'd1 << width) - 32'd1;
      end
      return idx & mask;
   endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file: write port, two read ports and scoreboard.
// The master side is the pipeline; the slave side is the register file.
interface reg_file_sb_if #(
   parameter int unsigned WIDTH  = 32'd8,
   parameter int unsigned ADDR_W = 32'd3
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WIDTH-1:0]  wdata;
   logic [ADDR_W-1:0] raddr1;
   logic [ADDR_W-1:0] raddr2;
   logic [WIDTH-1:0]  rdata1;
   logic [WIDTH-1:0]  rdata2;
   logic              alloc_en;
   logic [ADDR_W-1:0] alloc_addr;
   logic              busy1;
   logic              busy2;
   logic              hazard;

   modport master (
      output we, waddr, wdata, raddr1, raddr2, alloc_en, alloc_addr,
      input  rdata1, rdata2, busy1, busy2, hazard
   );

   modport slave (
      input  we, waddr, wdata, raddr1, raddr2, alloc_en, alloc_addr,
      output rdata1, rdata2, busy1, busy2, hazard
   );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy bits: allocation sets, writeback clears, allocation wins a tie.
// Lookups hide a busy bit that the same-cycle write is about to retire.
module reg_file_scoreboard #(
   parameter int unsigned DEPTH    = 32'd8,
   parameter int unsigned ADDR_W   = $clog2(DEPTH),
   parameter int unsigned ZERO_REG = 32'd0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic              alloc_en,
   input  logic [ADDR_W-1:0] alloc_addr,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic              busy1,
   output logic              busy2
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic             alloc_ok;

   function automatic logic lookup(
      input logic [DEPTH-1:0]  bq,
      input logic [ADDR_W-1:0] ra,
      input logic              w_en,
      input logic [ADDR_W-1:0] wa,
      input logic              a_en,
      input logic [ADDR_W-1:0] aa
   );
      logic res;
      res = bq[ra] & ~(w_en && (wa == ra) && !(a_en && (aa == ra)));
      if ((ZERO_REG == 32'd1) && (ra == '0)) begin
         res = 1'b0;
      end else begin
         res = res;
      end
      return res;
   endfunction

   // Allocations to the hardwired zero register are dropped.
   always_comb begin
      alloc_ok = alloc_en && !((ZERO_REG == 32'd1) && (alloc_addr == '0));
   end

   // Next busy vector: reset clears, set beats clear, otherwise hold.
   always_comb begin
      busy_d = busy_q;
      if (reset) begin
         busy_d = '0;
      end else begin
         for (int r = 0; r < int'(DEPTH); r++) begin
            if (alloc_ok && (alloc_addr == ADDR_W'(r))) begin
               busy_d[r] = 1'b1;
            end else if (we && (waddr == ADDR_W'(r))) begin
               busy_d[r] = 1'b0;
            end else begin
               busy_d[r] = busy_q[r];
            end
         end
      end
   end

   // Busy bit storage.
   always_ff @(posedge clk) begin
      busy_q <= busy_d;
   end

   // Per-port lookups with write-clear bypass.
   always_comb begin
      busy1 = lookup(busy_q, raddr1, we, waddr, alloc_en, alloc_addr);
      busy2 = lookup(busy_q, raddr2, we, waddr, alloc_en, alloc_addr);
   end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with write-through bypass, optional zero register, optional
// registered reads and a busy scoreboard for RAW hazard detection at decode.
module reg_file_sb
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH        = 32'd8,
   parameter int unsigned DEPTH        = 32'd8,
   parameter int unsigned ADDR_W       = $clog2(DEPTH),
   parameter int unsigned INIT_MODE    = 32'd1,
   parameter int unsigned ZERO_REG     = 32'd0,
   parameter int unsigned READ_LATENCY = 32'd0
) (
   input logic           clk,
   input logic           reset,
   reg_file_sb_if.slave  bus
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             wr_ok;
   logic [WIDTH-1:0] rd1_c;
   logic [WIDTH-1:0] rd2_c;
   logic             busy1_c;
   logic             busy2_c;

   // Writes to the hardwired zero register are dropped.
   always_comb begin
      wr_ok = bus.we && !((ZERO_REG == 32'd1) && (bus.waddr == '0));
   end

   // Next array contents: reset image or single-port write.
   always_comb begin
      mem_d = mem_q;
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (INIT_MODE == INIT_INDEX) begin
               mem_d[i] = WIDTH'(init_value(i, WIDTH));
            end else begin
               mem_d[i] = '0;
            end
         end
         if (ZERO_REG == 32'd1) begin
            mem_d[0] = '0;
         end else begin
            mem_d[0] = mem_d[0];
         end
      end else if (wr_ok) begin
         mem_d[bus.waddr] = bus.wdata;
      end else begin
         mem_d = mem_q;
      end
   end

   // Data array storage.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Read muxes: zero register beats bypass, bypass beats the array.
   always_comb begin
      rd1_c = mem_q[bus.raddr1];
      rd2_c = mem_q[bus.raddr2];
      if (wr_ok && (bus.waddr == bus.raddr1)) begin
         rd1_c = bus.wdata;
      end else begin
         rd1_c = rd1_c;
      end
      if (wr_ok && (bus.waddr == bus.raddr2)) begin
         rd2_c = bus.wdata;
      end else begin
         rd2_c = rd2_c;
      end
      if ((ZERO_REG == 32'd1) && (bus.raddr1 == '0)) begin
         rd1_c = '0;
      end else begin
         rd1_c = rd1_c;
      end
      if ((ZERO_REG == 32'd1) && (bus.raddr2 == '0)) begin
         rd2_c = '0;
      end else begin
         rd2_c = rd2_c;
      end
   end

   reg_file_scoreboard #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk        (clk),
      .reset      (reset),
      .we         (bus.we),
      .waddr      (bus.waddr),
      .alloc_en   (bus.alloc_en),
      .alloc_addr (bus.alloc_addr),
      .raddr1     (bus.raddr1),
      .raddr2     (bus.raddr2),
      .busy1      (busy1_c),
      .busy2      (busy2_c)
   );

   if (READ_LATENCY == 32'd1) begin : g_lat1
      logic [WIDTH-1:0] rdata1_q, rdata1_d;
      logic [WIDTH-1:0] rdata2_q, rdata2_d;
      logic             busy1_q, busy1_d;
      logic             busy2_q, busy2_d;

      // Output stage samples the latency-0 view; reset forces zeros.
      always_comb begin
         if (reset) begin
            rdata1_d = '0;
            rdata2_d = '0;
            busy1_d  = 1'b0;
            busy2_d  = 1'b0;
         end else begin
            rdata1_d = rd1_c;
            rdata2_d = rd2_c;
            busy1_d  = busy1_c;
            busy2_d  = busy2_c;
         end
      end

      // Output stage registers.
      always_ff @(posedge clk) begin
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
         busy1_q  <= busy1_d;
         busy2_q  <= busy2_d;
      end

      assign bus.rdata1 = rdata1_q;
      assign bus.rdata2 = rdata2_q;
      assign bus.busy1  = busy1_q;
      assign bus.busy2  = busy2_q;
   end else begin : g_lat0
      assign bus.rdata1 = rd1_c;
      assign bus.rdata2 = rd2_c;
      assign bus.busy1  = busy1_c;
      assign bus.busy2  = busy2_c;
   end

   assign bus.hazard = bus.busy1 | bus.busy2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default, zero-register and registered-read
// configurations, each checked against hand-computed values.
module tb_reg_file_sb;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   reg_file_sb_if #(.WIDTH(32'd8), .ADDR_W(32'd3)) bif0 ();
   reg_file_sb_if #(.WIDTH(32'd8), .ADDR_W(32'd3)) bifz ();
   reg_file_sb_if #(.WIDTH(32'd8), .ADDR_W(32'd3)) bifl ();

   reg_file_sb #(.INIT_MODE(32'd1), .ZERO_REG(32'd0), .READ_LATENCY(32'd0))
      dut0 (.clk(clk), .reset(reset), .bus(bif0));
   reg_file_sb #(.INIT_MODE(32'd1), .ZERO_REG(32'd1), .READ_LATENCY(32'd0))
      dutz (.clk(clk), .reset(reset), .bus(bifz));
   reg_file_sb #(.INIT_MODE(32'd1), .ZERO_REG(32'd0), .READ_LATENCY(32'd1))
      dutl (.clk(clk), .reset(reset), .bus(bifl));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      bif0.we = 1'b0; bif0.waddr = 3'd0; bif0.wdata = 8'h00; bif0.raddr1 = 3'd0;
      bif0.raddr2 = 3'd0; bif0.alloc_en = 1'b0; bif0.alloc_addr = 3'd0;
      bifz.we = 1'b0; bifz.waddr = 3'd0; bifz.wdata = 8'h00; bifz.raddr1 = 3'd0;
      bifz.raddr2 = 3'd0; bifz.alloc_en = 1'b0; bifz.alloc_addr = 3'd0;
      bifl.we = 1'b0; bifl.waddr = 3'd0; bifl.wdata = 8'h00; bifl.raddr1 = 3'd0;
      bifl.raddr2 = 3'd0; bifl.alloc_en = 1'b0; bifl.alloc_addr = 3'd0;
      tick();
      reset = 1'b0;

      // Registered read port reads zero in the cycle after reset.
      check_val("lat1_post_reset_rd1", 32'(bifl.rdata1), 32'h0);

      // Index-mode reset contents, no hazards.
      bif0.raddr1 = 3'd5; bif0.raddr2 = 3'd7; #1;
      check_val("init_rd1", 32'(bif0.rdata1), 32'h05);
      check_val("init_rd2", 32'(bif0.rdata2), 32'h07);
      check_val("init_busy1", 32'(bif0.busy1), 32'h0);
      check_val("init_busy2", 32'(bif0.busy2), 32'h0);
      check_val("init_hazard", 32'(bif0.hazard), 32'h0);

      // Write-through bypass, then stored value.
      bif0.we = 1'b1; bif0.waddr = 3'd3; bif0.wdata = 8'hA5; bif0.raddr1 = 3'd3; #1;
      check_val("bypass_rd1", 32'(bif0.rdata1), 32'hA5);
      tick();
      bif0.we = 1'b0; #1;
      check_val("stored_rd1", 32'(bif0.rdata1), 32'hA5);

      // Allocate r4, see hazard, retire it with a forwarded write.
      bif0.alloc_en = 1'b1; bif0.alloc_addr = 3'd4;
      tick();
      bif0.alloc_en = 1'b0; bif0.raddr2 = 3'd4; #1;
      check_val("alloc_busy2", 32'(bif0.busy2), 32'h1);
      check_val("alloc_hazard", 32'(bif0.hazard), 32'h1);
      bif0.we = 1'b1; bif0.waddr = 3'd4; bif0.wdata = 8'h3C; #1;
      check_val("wclear_busy2", 32'(bif0.busy2), 32'h0);
      check_val("wclear_rd2", 32'(bif0.rdata2), 32'h3C);
      check_val("wclear_hazard", 32'(bif0.hazard), 32'h0);
      tick();
      bif0.we = 1'b0; #1;
      check_val("cleared_busy2", 32'(bif0.busy2), 32'h0);
      check_val("cleared_rd2", 32'(bif0.rdata2), 32'h3C);

      // Same-cycle alloc and write to busy r2: new producer keeps it busy.
      bif0.alloc_en = 1'b1; bif0.alloc_addr = 3'd2;
      tick();
      bif0.we = 1'b1; bif0.waddr = 3'd2; bif0.wdata = 8'h5A; bif0.raddr1 = 3'd2; #1;
      check_val("tie_busy1_same", 32'(bif0.busy1), 32'h1);
      check_val("tie_rd1_same", 32'(bif0.rdata1), 32'h5A);
      tick();
      bif0.we = 1'b0; bif0.alloc_en = 1'b0; #1;
      check_val("tie_busy1_next", 32'(bif0.busy1), 32'h1);
      check_val("tie_rd1_next", 32'(bif0.rdata1), 32'h5A);

      // Reset beats a concurrent write and allocation, and drops pending r2.
      reset = 1'b1; bif0.we = 1'b1; bif0.waddr = 3'd6; bif0.wdata = 8'h77;
      bif0.alloc_en = 1'b1; bif0.alloc_addr = 3'd6;
      tick();
      reset = 1'b0; bif0.we = 1'b0; bif0.alloc_en = 1'b0;
      bif0.raddr1 = 3'd6; bif0.raddr2 = 3'd2; #1;
      check_val("rst_rd1", 32'(bif0.rdata1), 32'h06);
      check_val("rst_rd2", 32'(bif0.rdata2), 32'h02);
      check_val("rst_busy1", 32'(bif0.busy1), 32'h0);
      check_val("rst_busy2", 32'(bif0.busy2), 32'h0);

      // Zero register ignores writes and allocations.
      bifz.raddr2 = 3'd1; #1;
      check_val("zr_rd2_r1", 32'(bifz.rdata2), 32'h01);
      bifz.we = 1'b1; bifz.waddr = 3'd0; bifz.wdata = 8'hFF;
      bifz.alloc_en = 1'b1; bifz.alloc_addr = 3'd0; bifz.raddr1 = 3'd0; #1;
      check_val("zr_rd1_same", 32'(bifz.rdata1), 32'h0);
      check_val("zr_busy1_same", 32'(bifz.busy1), 32'h0);
      tick();
      bifz.we = 1'b0; bifz.alloc_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_val("zr_rd1_later", 32'(bifz.rdata1), 32'h0);
         check_val("zr_busy1_later", 32'(bifz.busy1), 32'h0);
         tick();
      end

      // Registered reads: address in one cycle, data the next.
      bifl.raddr1 = 3'd6; #1;
      check_val("lat1_rd1_before", 32'(bifl.rdata1), 32'h0);
      tick();
      check_val("lat1_rd1_after", 32'(bifl.rdata1), 32'h06);
      bifl.we = 1'b1; bifl.waddr = 3'd6; bifl.wdata = 8'h11;
      tick();
      check_val("lat1_bypass_rd1", 32'(bifl.rdata1), 32'h11);
      bifl.we = 1'b0; bifl.alloc_en = 1'b1; bifl.alloc_addr = 3'd5; bifl.raddr2 = 3'd5;
      tick();
      bifl.alloc_en = 1'b0;
      check_val("lat1_busy2_early", 32'(bifl.busy2), 32'h0);
      tick();
      check_val("lat1_busy2", 32'(bifl.busy2), 32'h1);
      check_val("lat1_hazard", 32'(bifl.hazard), 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("lat1_rst_rd1_zero", 32'(bifl.rdata1), 32'h0);
      check_val("lat1_rst_busy2_zero", 32'(bifl.busy2), 32'h0);
      tick();
      check_val("lat1_rst_rd1", 32'(bifl.rdata1), 32'h06);
      check_val("lat1_rst_busy2", 32'(bifl.busy2), 32'h0);
      check_val("lat1_rst_hazard", 32'(bifl.hazard), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised, clocked successor to the CPU's 8x8 register file: DEPTH registers of WIDTH bits, two read ports, one write port.
- Adds write-through bypass, an optional hardwired zero register and an optional registered-read mode.
- Adds a per-register busy scoreboard so the pipeline decode stage can detect RAW hazards against in-flight writes.
- Sits between decode (reads, allocation) and writeback (write, busy clear).

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 8, number of registers; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), register address width (derived; do not override).
- INIT_MODE, 1, reset contents: 0 = all zero; 1 = register i holds i truncated to WIDTH.
- ZERO_REG, 0, 1 = register 0 always reads 0; writes and allocations to it are ignored.
- READ_LATENCY, 0, 0 = combinational reads; 1 = reads registered one cycle.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- we, in, 1, write enable (writeback).
- waddr, in, ADDR_W, write address.
- wdata, in, WIDTH, write data.
- raddr1, in, ADDR_W, read port 1 address.
- raddr2, in, ADDR_W, read port 2 address.
- rdata1, out, WIDTH, read port 1 data.
- rdata2, out, WIDTH, read port 2 data.
- alloc_en, in, 1, mark register alloc_addr busy (instruction issued with this destination).
- alloc_addr, in, ADDR_W, destination being allocated.
- busy1, out, 1, register at raddr1 has a pending write.
- busy2, out, 1, register at raddr2 has a pending write.
- hazard, out, 1, busy1 | busy2.

Behaviour:
- Reset:
  - Sampled on the clk edge while reset=1.
  - Registers load per INIT_MODE (register 0 loads 0 when ZERO_REG=1).
  - All busy bits clear.
  - When READ_LATENCY=1, rdata1/rdata2 read 0 in the cycle after reset.
  - reset overrides we and alloc_en in the same cycle.
  - Reset asserted mid-operation discards any pending allocations.
- Write:
  - When we=1, mem[waddr] <= wdata at the clk edge.
  - No effect when ZERO_REG=1 and waddr=0.
- Busy bits (per register r, at the clk edge):
  - Set if alloc_en && alloc_addr==r.
  - Else cleared if we && waddr==r.
  - Else held.
  - Allocation and write to the same r in the same cycle leave r busy: the new producer wins.
  - Allocation to a register that is already busy keeps it busy; there is no counting.
  - With ZERO_REG=1, register 0 is never busy.
- Read, READ_LATENCY=0:
  - rdata = mem[raddr], combinational.
  - Bypass: if we && waddr==raddr (and not the zero register), rdata = wdata in the same cycle.
  - busyN = busy[raddrN] & ~(we && waddr==raddrN && !alloc_hit), where alloc_hit means alloc_en && alloc_addr==raddrN. The value being written is forwarded, so there is no hazard.
- Read, READ_LATENCY=1:
  - rdataN and busyN are registered versions of the latency-0 values, including bypass, sampled at the edge.
  - Output appears one cycle after the address.
  - hazard follows busy1|busy2 with the same latency.
- Zero register (ZERO_REG=1): reads of address 0 return 0 and busy 0, regardless of bypass.
- Both read ports are independent. Both may address the same register and must return identical data.
- No out-of-range addresses exist because DEPTH is a power of two.

Decomposition:
- Package regfile_pkg:
  - INIT_ZERO = 0 and INIT_INDEX = 1 constants.
  - Function init_value(idx, width) returning idx truncated to width.
- Sub-module reg_file_scoreboard:
  - Holds the DEPTH busy bits and their set/clear priority.
  - Provides the per-port busy lookup with write-clear bypass.
- The top level holds the data array, bypass muxes and the optional output register stage.

Test Plan:
- Reset with INIT_MODE=1 and defaults, then read raddr1=5, raddr2=7 -> rdata1=5, rdata2=7, busy1=busy2=0, hazard=0.
- we=1, waddr=3, wdata=8'hA5, raddr1=3 in the same cycle (latency 0) -> rdata1=8'hA5 immediately (bypass); next cycle with we=0, still 8'hA5.
- alloc_en=1, alloc_addr=4; next cycle raddr2=4:
  - -> busy2=1, hazard=1.
  - Then we=1, waddr=4, wdata=8'h3C -> busy2=0 in that cycle with rdata2=8'h3C.
  - busy[4] is clear afterwards.
- Same cycle alloc_addr=2 and we, waddr=2 while 2 is busy -> busy[2] remains 1 next cycle; the data register updates to wdata.
- ZERO_REG=1: we=1, waddr=0, wdata=8'hFF and alloc_addr=0 -> raddr1=0 gives rdata1=0, busy1=0 in all later cycles.
- READ_LATENCY=1: raddr1=6 at cycle n -> rdata1=6 at cycle n+1. Asserting reset after writing 8'h11 to reg 6 -> rdata1=6 after reset (INIT_MODE=1) and all busy bits clear.
